// File: rtl/counter_seek_ctrl.sv
// counter_seek_ctrl: drives the up/ctrl (hold) inputs of an up/down counter so
// that it walks from its sampled value to a target, one pulse every
// step_div+1 cycles, then holds and pulses done.
// Optional build macro SEEK_SHORTEST_PATH_EN: pick the direction modulo
// 2^WIDTH (shortest way round, counter may wrap) instead of unsigned compare.
module counter_seek_ctrl #(
    parameter int WIDTH = 32,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] target,
    input  logic [DIV_W-1:0] step_div,
    input  logic [WIDTH-1:0] cnt_in,
    output logic             up,
    output logic             ctrl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] steps
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEEK = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [DIV_W-1:0] r_div, w_div_nxt;       // phase within the current step period
    logic [DIV_W-1:0] r_dmax, w_dmax_nxt;     // latched step_div
    logic [WIDTH-1:0] r_dist, w_dist_nxt;     // pulses still to issue
    logic [WIDTH-1:0] r_steps, w_steps_nxt;
    logic             r_up, w_up_nxt;
    logic             r_ctrl, w_ctrl_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;

    logic [WIDTH-1:0] w_d_up;
    logic [WIDTH-1:0] w_dist_new;
    logic             w_dir_new;
    logic             w_pulse;
    logic [WIDTH-1:0] w_rem;
    logic [DIV_W-1:0] w_phase_nxt;

    assign w_d_up = target - cnt_in;

`ifdef SEEK_SHORTEST_PATH_EN
    localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};

    // Shortest way round the ring; an exact half-turn goes up.
    always_comb begin
        w_dir_new  = (w_d_up <= HALF);
        w_dist_new = w_dir_new ? w_d_up : (~w_d_up + 1'b1);
    end
`else
    // Plain unsigned compare; the counter never has to wrap.
    always_comb begin
        w_dir_new  = (target >= cnt_in);
        w_dist_new = w_dir_new ? w_d_up : (cnt_in - target);
    end
`endif

    // A pulse is happening this cycle when SEEK holds ctrl low; the target is
    // folded into the distance at start, so it needs no register of its own.
    assign w_pulse     = (r_state == S_SEEK) && !r_ctrl;
    assign w_rem       = r_dist - {{(WIDTH-1){1'b0}}, w_pulse};
    assign w_phase_nxt = (r_div == r_dmax) ? '0 : r_div + 1'b1;

    // Next state and next registered outputs (ctrl is decided one cycle ahead).
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_dmax_nxt  = r_dmax;
        w_dist_nxt  = r_dist;
        w_steps_nxt = r_steps;
        w_up_nxt    = r_up;
        w_ctrl_nxt  = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_up_nxt    = w_dir_new;
                    w_dist_nxt  = w_dist_new;
                    w_dmax_nxt  = step_div;
                    w_div_nxt   = '0;
                    w_steps_nxt = '0;
                    if (w_dist_new == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_SEEK;
                        // With no divide, the first pulse lands right away.
                        w_ctrl_nxt  = (step_div != '0);
                    end
                end
            end
            S_SEEK: begin
                w_dist_nxt = w_rem;
                if (w_pulse) w_steps_nxt = r_steps + 1'b1;
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_rem == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_div_nxt  = w_phase_nxt;
                    w_ctrl_nxt = (w_phase_nxt != r_dmax);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (w_state_nxt == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_dmax  <= '0;
            r_dist  <= '0;
            r_steps <= '0;
            r_up    <= 1'b1;
            r_ctrl  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_dmax  <= w_dmax_nxt;
            r_dist  <= w_dist_nxt;
            r_steps <= w_steps_nxt;
            r_up    <= w_up_nxt;
            r_ctrl  <= w_ctrl_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign up    = r_up;
    assign ctrl  = r_ctrl;
    assign busy  = r_busy;
    assign done  = r_done;
    assign steps = r_steps;

endmodule

// File: tb/tb_counter_seek_ctrl.sv
// Bench for counter_seek_ctrl: a timing-formula model checked every cycle,
// plus literal pulse/done offsets for each directed seek. A bench counter
// follows up/ctrl and feeds cnt_in.
module tb_counter_seek_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] target = '0;
    logic [15:0] step_div = '0;
    logic [31:0] cnt_in;
    logic        up, ctrl, busy, done;
    logic [31:0] steps;

    counter_seek_ctrl #(.WIDTH(32), .DIV_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .target(target), .step_div(step_div), .cnt_in(cnt_in),
        .up(up), .ctrl(ctrl), .busy(busy), .done(done), .steps(steps)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Counter being driven.
    logic        load_req = 1'b0;
    logic [31:0] load_val = '0;
    logic [31:0] tcnt = '0;
    always @(posedge clk) begin
        if (load_req)   tcnt <= load_val;
        else if (!ctrl) tcnt <= up ? tcnt + 32'd1 : tcnt - 32'd1;
    end
    assign cnt_in = tcnt;

    // Model: 0 idle, 1 seek, 2 done. Pulses placed by elapsed time since start.
    longint cyc = 0;
    int     m_st = 0;
    bit     m_up = 1'b1;
    bit     e_ctrl = 1'b1;
    bit     m_vld = 1'b0;
    longint m_steps = 0, m_dist = 0, m_D = 0, m_t0 = 0;

    always @(posedge clk) begin
        longint c, t, dup, j;
        if (rst) begin
            m_st = 0; m_up = 1'b1; m_steps = 0; e_ctrl = 1'b1;
        end else begin
            if (m_st == 1 && !e_ctrl) m_steps++;
            case (m_st)
                0: if (start) begin
                    c = cnt_in; t = target;
                    dup = (t - c) & 64'hFFFF_FFFF;
`ifdef SEEK_SHORTEST_PATH_EN
                    if (dup <= (64'd1 << 31)) begin m_up = 1'b1; m_dist = dup; end
                    else begin m_up = 1'b0; m_dist = (64'd1 << 32) - dup; end
`else
                    if (t >= c) begin m_up = 1'b1; m_dist = t - c; end
                    else begin m_up = 1'b0; m_dist = c - t; end
`endif
                    m_D = step_div; m_t0 = cyc; m_steps = 0;
                    m_st = (m_dist == 0) ? 2 : 1;
                end
                1: if (abort) m_st = 0;
                   else if (m_steps == m_dist) m_st = 2;
                default: m_st = 0;
            endcase
            j = cyc - m_t0;   // index of the coming cycle counted from T+1
            e_ctrl = !(m_st == 1 && j >= m_D && ((j - m_D) % (m_D + 1)) == 0
                       && ((j - m_D) / (m_D + 1)) < m_dist);
        end
        cyc++;
        m_vld = 1'b1;
    end

    always @(negedge clk) begin
        if (m_vld) begin
            chk("cmp_ctrl", ctrl, e_ctrl);
            chk("cmp_up", up, m_up);
            chk("cmp_busy", busy, m_st != 0);
            chk("cmp_done", done, m_st == 2);
            chk("cmp_steps", steps, m_steps);
        end
    end

    // Pulse/done offsets relative to the start cycle.
    bit     rec_en = 1'b0;
    longint t_start = 0;
    int     pq[$];
    int     done_off = -1;
    always @(negedge clk) begin
        if (rec_en) begin
            if (!ctrl) pq.push_back(int'(cyc - t_start));
            if (done && done_off < 0) done_off = int'(cyc - t_start);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic run_seek(input logic [31:0] c, input logic [31:0] t, input logic [15:0] d,
                            input int abort_off, input int dup_off, input int ncyc);
        load_val = c; load_req = 1'b1; tick(); load_req = 1'b0;
        target = t; step_div = d; start = 1'b1;
        t_start = cyc; pq.delete(); done_off = -1; rec_en = 1'b1;
        tick(); start = 1'b0;
        for (int off = 1; off <= ncyc; off++) begin
            abort = (off == abort_off);
            start = (off == dup_off);
            target = (off == dup_off) ? t + 32'd500 : t;
            tick();
        end
        abort = 1'b0; start = 1'b0; target = t; rec_en = 1'b0;
    endtask

    task automatic chk_pulses(input string nm, input int e[$]);
        chk({nm, "_npulse"}, pq.size(), e.size());
        for (int i = 0; i < e.size() && i < pq.size(); i++)
            chk($sformatf("%s_pulse%0d", nm, i), pq[i], e[i]);
    endtask

    initial begin
        int e[$];
        rst = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            chk("rst_up", up, 1); chk("rst_ctrl", ctrl, 1);
            chk("rst_busy", busy, 0); chk("rst_done", done, 0);
            chk("rst_steps", steps, 0);
        end

        // 10 -> 13, no divide
        run_seek(32'd10, 32'd13, 16'd0, 0, 0, 6);
        e = {1, 2, 3}; chk_pulses("up3", e);
        chk("up3_done", done_off, 4); chk("up3_steps", steps, 3);
        chk("up3_up", up, 1); chk("up3_cnt", tcnt, 13);

        // 20 -> 18, divide by 3
        run_seek(32'd20, 32'd18, 16'd2, 0, 0, 9);
        e = {3, 6}; chk_pulses("dn2", e);
        chk("dn2_done", done_off, 7); chk("dn2_steps", steps, 2);
        chk("dn2_up", up, 0); chk("dn2_cnt", tcnt, 18);

        // already there
        run_seek(32'h55, 32'h55, 16'd4, 0, 0, 3);
        chk("zero_npulse", pq.size(), 0);
        chk("zero_done", done_off, 1); chk("zero_steps", steps, 0);
        chk("zero_cnt", tcnt, 32'h55);

        // abort after 4 pulses; a start mid-seek is ignored
        run_seek(32'd0, 32'd100, 16'd0, 4, 2, 8);
        e = {1, 2, 3, 4}; chk_pulses("abt", e);
        chk("abt_done", done_off, -1); chk("abt_steps", steps, 4);
        chk("abt_cnt", tcnt, 4); chk("abt_busy", busy, 0);

`ifdef SEEK_SHORTEST_PATH_EN
        run_seek(32'hFFFF_FFFE, 32'd1, 16'd0, 0, 0, 6);
        e = {1, 2, 3}; chk_pulses("wrap", e);
        chk("wrap_done", done_off, 4); chk("wrap_up", up, 1);
        chk("wrap_steps", steps, 3); chk("wrap_cnt", tcnt, 1);
`else
        run_seek(32'hFFFF_FFFE, 32'd1, 16'd0, 3, 0, 6);
        e = {1, 2, 3}; chk_pulses("wrap", e);
        chk("wrap_done", done_off, -1); chk("wrap_up", up, 0);
        chk("wrap_steps", steps, 3); chk("wrap_cnt", tcnt, 32'hFFFF_FFFB);
`endif

        // reset in the middle of a seek
        load_val = 32'd0; load_req = 1'b1; tick(); load_req = 1'b0;
        target = 32'd50; step_div = 16'd1; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        @(negedge clk);
        chk("mrst_ctrl", ctrl, 1); chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0); chk("mrst_steps", steps, 0);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
